// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner.
// One row is driven low per step, the synchronized columns are captured into
// a 16-bit frame snapshot, and each completed frame is classified (none,
// single, multi) and debounced across whole frames before a key is reported.
module keypad_scanner #(
  parameter int CLK_DIV      = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] kb_row,
  input  logic [3:0] kb_col,
  output logic [1:0] scan_idx,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  logic [3:0]       col_s1_q, col_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       scan_idx_q;
  logic [3:0]       kb_row_q;
  logic [15:0]      snap_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;

  logic             tick, frame_end;
  logic [15:0]      frame_low;
  logic             is_none, is_single;
  logic [3:0]       low_idx;
  logic [CNT_W-1:0] cnt_inc;

  assign tick      = (div_q == DIV_LAST);
  assign frame_end = tick && (scan_idx_q == 2'd3);
  // Row 3 is still in the synchronizer on the frame-end tick, so splice it in.
  assign frame_low = ~{col_s2_q, snap_q[11:0]};
  assign is_none   = (frame_low == 16'h0000);
  assign is_single = !is_none && ((frame_low & (frame_low - 16'h0001)) == 16'h0000);
  assign cnt_inc   = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q <= 4'b1111;
      col_s2_q <= 4'b1111;
    end else begin
      col_s1_q <= kb_col;
      col_s2_q <= col_s1_q;
    end
  end

  // Row step divider, row drive and per-row column snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      scan_idx_q <= 2'd0;
      kb_row_q   <= 4'b1110;
      snap_q     <= '1;
    end else if (tick) begin
      div_q                         <= '0;
      scan_idx_q                    <= scan_idx_q + 2'd1;
      kb_row_q                      <= ~(4'b0001 << (scan_idx_q + 2'd1));
      snap_q[{scan_idx_q, 2'b00} +: 4] <= col_s2_q;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Position of the closed key; only meaningful when the frame is a single press.
  always_comb begin
    low_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_low[i]) low_idx = 4'(i);
    end
  end

  // Debounce FSM next state; only moves on a frame-end tick.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (is_single) begin
            cand_d = low_idx;
            if (DEBOUNCE_CNT <= 1) begin
              state_d     = HELD;
              cnt_d       = '0;
              key_code_d  = low_idx;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
            end else begin
              state_d = PRESS_DB;
              cnt_d   = CNT_ONE;
            end
          end
        end
        PRESS_DB: begin
          if (is_single && (low_idx == cand_q)) begin
            if (cnt_inc >= CNT_MAX) begin
              state_d     = HELD;
              cnt_d       = '0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          // Any closed key (same, other, or chord) keeps the press alive; no rollover.
          if (is_none) begin
            if (DEBOUNCE_CNT <= 1) begin
              state_d    = IDLE;
              cnt_d      = '0;
              key_down_d = 1'b0;
            end else begin
              state_d = RELEASE_DB;
              cnt_d   = CNT_ONE;
            end
          end
        end
        RELEASE_DB: begin
          if (is_none) begin
            if (cnt_inc >= CNT_MAX) begin
              state_d    = IDLE;
              cnt_d      = '0;
              key_down_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Debounce FSM and key output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign kb_row    = kb_row_q;
  assign scan_idx  = scan_idx_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule
